// File: rtl/branch_pc_sequencer_pkg.sv
// Shared definitions for the branch/jump PC sequencer.
//   - op_kind encodings for the control-unit handshake
//   - sequencer state enum
//   - default datapath widths
package branch_pc_sequencer_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int IMM_WIDTH_DEF  = 19;

  typedef enum logic [1:0] {
    OP_BR  = 2'b00,
    OP_JR  = 2'b01,
    OP_JAL = 2'b10,
    OP_RSV = 2'b11
  } op_kind_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EVAL   = 2'b01,
    UPDATE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/branch_pc_sequencer_if.sv
// Control-unit / datapath bundle for the branch PC sequencer.
//   master : control unit side (drives pc_inc, start, op_kind, con_flag,
//            imm, rb_value; observes pc, busy, done, taken, link_we,
//            link_value)
//   slave  : sequencer side (the reverse)
interface branch_pc_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 19
);

  logic                  pc_inc;
  logic                  start;
  logic [1:0]            op_kind;
  logic                  con_flag;
  logic [IMM_WIDTH-1:0]  imm;
  logic [DATA_WIDTH-1:0] rb_value;
  logic [DATA_WIDTH-1:0] pc;
  logic                  busy;
  logic                  done;
  logic                  taken;
  logic                  link_we;
  logic [DATA_WIDTH-1:0] link_value;

  modport master (
    output pc_inc, start, op_kind, con_flag, imm, rb_value,
    input  pc, busy, done, taken, link_we, link_value
  );

  modport slave (
    input  pc_inc, start, op_kind, con_flag, imm, rb_value,
    output pc, busy, done, taken, link_we, link_value
  );

endinterface

// File: rtl/branch_pc_sequencer_target_adder.sv
// branch_target_adder: combinational PC-relative target generation.
// Sign-extends the offset to the PC width and adds it modulo 2^DATA_WIDTH.
//   pc     in  DATA_WIDTH  base address
//   imm    in  IMM_WIDTH   signed offset
//   target out DATA_WIDTH  pc + sign_extend(imm)
module branch_target_adder #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 19
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [IMM_WIDTH-1:0]  imm,
  output logic [DATA_WIDTH-1:0] target
);

  logic [DATA_WIDTH-1:0] imm_ext;

  assign imm_ext = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign target  = pc + imm_ext;

endmodule

// File: rtl/branch_pc_sequencer.sv
// Program counter owner and branch/jump sequencer.
// Increments the PC on fetch requests and runs a 3-cycle sequence
// (start -> EVAL -> UPDATE -> done) for conditional branch, jr and jal.
//   clk    in  system clock, rising edge
//   clear  in  asynchronous active-low reset
//   bus    slave modport: pc_inc/start/op_kind/con_flag/imm/rb_value in,
//          pc/busy/done/taken/link_we/link_value out
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | accepts pc_inc and start; start has priority
// EVAL   | samples con_flag, computes target and take decision
// UPDATE | writes PC if taken, pulses done/taken/link_we on exit
module branch_pc_sequencer
  import branch_pc_sequencer_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int                    IMM_WIDTH  = IMM_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                   clk,
  input  logic                   clear,
  branch_pc_sequencer_if.slave   bus
);

  seq_state_e            state_q, state_d;
  op_kind_e              op_q, op_d;
  logic [IMM_WIDTH-1:0]  imm_q, imm_d;
  logic [DATA_WIDTH-1:0] rb_q, rb_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic                  take_q, take_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  done_q, done_d;
  logic                  taken_q, taken_d;
  logic                  link_we_q, link_we_d;
  logic [DATA_WIDTH-1:0] link_value_q, link_value_d;
  logic [DATA_WIDTH-1:0] br_target;

  // PC is stable while busy, so the relative target uses the live PC.
  branch_target_adder #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMM_WIDTH  (IMM_WIDTH)
  ) u_target_adder (
    .pc     (pc_q),
    .imm    (imm_q),
    .target (br_target)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= IDLE;
      op_q         <= OP_BR;
      imm_q        <= '0;
      rb_q         <= '0;
      target_q     <= '0;
      take_q       <= 1'b0;
      pc_q         <= RESET_PC;
      done_q       <= 1'b0;
      taken_q      <= 1'b0;
      link_we_q    <= 1'b0;
      link_value_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      imm_q        <= imm_d;
      rb_q         <= rb_d;
      target_q     <= target_d;
      take_q       <= take_d;
      pc_q         <= pc_d;
      done_q       <= done_d;
      taken_q      <= taken_d;
      link_we_q    <= link_we_d;
      link_value_q <= link_value_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    imm_d        = imm_q;
    rb_d         = rb_q;
    target_d     = target_q;
    take_d       = take_q;
    pc_d         = pc_q;
    done_d       = 1'b0;
    taken_d      = 1'b0;
    link_we_d    = 1'b0;
    link_value_d = link_value_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = op_kind_e'(bus.op_kind);
          imm_d   = bus.imm;
          rb_d    = bus.rb_value;
          state_d = EVAL;
        end else if (bus.pc_inc) begin
          pc_d = pc_q + DATA_WIDTH'(1);
        end
      end

      EVAL: begin
        // con_flag is sampled here: the CON flop settles one cycle after start.
        case (op_q)
          OP_BR: begin
            target_d = br_target;
            take_d   = bus.con_flag;
          end
          OP_JR, OP_JAL: begin
            target_d = rb_q;
            take_d   = 1'b1;
          end
          default: begin
            target_d = pc_q;
            take_d   = 1'b0;
          end
        endcase
        state_d = UPDATE;
      end

      UPDATE: begin
        if (take_q) begin
          pc_d = target_q;
        end
        done_d  = 1'b1;
        taken_d = take_q;
        if (op_q == OP_JAL) begin
          link_we_d    = 1'b1;
          link_value_d = pc_q;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.pc         = pc_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.taken      = taken_q;
  assign bus.link_we    = link_we_q;
  assign bus.link_value = link_value_q;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
module tb_branch_pc_sequencer;
  import branch_pc_sequencer_pkg::*;

  localparam int DW = 32;
  localparam int IW = 19;

  logic clk   = 1'b0;
  logic clear = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;
  logic [DW-1:0] exp_pc;

  always #5 clk = ~clk;

  branch_pc_sequencer_if #(.DATA_WIDTH(DW), .IMM_WIDTH(IW)) bus ();

  branch_pc_sequencer #(
    .DATA_WIDTH (DW),
    .IMM_WIDTH  (IW),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input int n);
    bus.pc_inc = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      exp_pc = exp_pc + 1;
    end
    bus.pc_inc = 1'b0;
    check("fetch_pc", bus.pc, exp_pc);
  endtask

  // Reference: target/take from the instruction semantics, applied at done.
  task automatic run_seq(input logic [1:0] op, input logic [IW-1:0] imm,
                         input logic [DW-1:0] rb, input logic con,
                         input logic con_late, input logic inc_start,
                         input logic inc_busy);
    logic [DW-1:0] target;
    logic [DW-1:0] pc_before;
    logic          take;
    int            offset;
    pc_before = exp_pc;
    offset    = int'($signed(imm));
    case (op)
      2'd0:    begin target = exp_pc + DW'(offset); take = con;  end
      2'd1,
      2'd2:    begin target = rb;                   take = 1'b1; end
      default: begin target = exp_pc;               take = 1'b0; end
    endcase

    bus.start    = 1'b1;
    bus.op_kind  = op;
    bus.imm      = imm;
    bus.rb_value = rb;
    bus.pc_inc   = inc_start;
    bus.con_flag = ~con;  // wrong value at start: must not be the one used
    step();               // now in EVAL
    bus.start    = 1'b0;
    bus.pc_inc   = inc_busy;
    bus.con_flag = con;
    bus.op_kind  = 2'($urandom);
    bus.imm      = IW'($urandom);
    bus.rb_value = $urandom;
    check("eval_busy", bus.busy, 1);
    check("eval_pc", bus.pc, pc_before);
    check("eval_done", bus.done, 0);
    step();               // now in UPDATE
    bus.con_flag = con_late;
    bus.start    = inc_busy;
    check("upd_busy", bus.busy, 1);
    check("upd_pc", bus.pc, pc_before);
    step();               // sequence complete
    bus.start  = 1'b0;
    bus.pc_inc = 1'b0;
    if (take) exp_pc = target;
    check("done_pc", bus.pc, exp_pc);
    check("done_pulse", bus.done, 1);
    check("done_taken", bus.taken, take);
    check("done_link_we", bus.link_we, op == 2'd2);
    check("done_busy", bus.busy, 0);
    if (op == 2'd2) check("link_value", bus.link_value, pc_before);
    step();
    check("done_drop", bus.done, 0);
    check("link_we_drop", bus.link_we, 0);
    check("post_pc", bus.pc, exp_pc);
  endtask

  initial begin
    bus.pc_inc   = 1'b1;
    bus.start    = 1'b0;
    bus.op_kind  = 2'd0;
    bus.con_flag = 1'b0;
    bus.imm      = '0;
    bus.rb_value = '0;
    exp_pc       = 32'h0;

    // Reset with pc_inc asserted
    repeat (2) step();
    check("rst_pc", bus.pc, 32'h0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_taken", bus.taken, 0);
    check("rst_link_we", bus.link_we, 0);
    check("rst_link_value", bus.link_value, 0);
    bus.pc_inc = 1'b0;
    clear      = 1'b1;
    step();
    fetch(3);
    check("fetch3_pc", bus.pc, 32'h3);

    // Conditional branch taken
    run_seq(2'd1, '0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    run_seq(2'd0, 19'h00005, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("br_taken_pc", bus.pc, 32'h15);

    // Conditional branch not taken, flag rises in UPDATE
    run_seq(2'd1, '0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    run_seq(2'd0, 19'h7FFFC, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("br_not_taken_pc", bus.pc, 32'h10);

    // jal with pc_inc/start during busy
    run_seq(2'd1, '0, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    run_seq(2'd2, '0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
    check("jal_pc", bus.pc, 32'h100);

    // start beats pc_inc
    run_seq(2'd1, '0, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0);
    check("prio_pc", bus.pc, 32'h40);

    // Increment wrap
    run_seq(2'd1, '0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch(1);
    check("wrap_pc", bus.pc, 32'h0);

    // Negative offset wrap
    run_seq(2'd1, '0, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_seq(2'd0, 19'h7FFFD, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("neg_wrap_pc", bus.pc, 32'hFFFF_FFFF);

    // Reserved op
    run_seq(2'd3, 19'h00010, 32'h1234, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset during EVAL
    bus.start    = 1'b1;
    bus.op_kind  = 2'd1;
    bus.rb_value = 32'h80;
    step();
    bus.start = 1'b0;
    check("mid_busy", bus.busy, 1);
    clear = 1'b0;
    #1;
    exp_pc = 32'h0;
    check("mid_rst_pc", bus.pc, exp_pc);
    check("mid_rst_busy", bus.busy, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_no_done", bus.done, 0);
      check("mid_pc_hold", bus.pc, exp_pc);
    end
    clear = 1'b1;
    step();
    fetch(2);

    // Randomized sequences against the reference
    for (int i = 0; i < 24; i++) begin
      run_seq(2'($urandom_range(0, 3)), IW'($urandom), $urandom,
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      fetch($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
